// File: rtl/multibyte_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// multibyte_add_sequencer_pkg
// Shared definitions for the byte-serial add/subtract sequencer:
//   BYTE_W  - width of the datapath slice processed per cycle
//   state_t - sequencer states (IDLE accepts, RUN iterates bytes, DONE holds)
// -----------------------------------------------------------------------------
package multibyte_add_sequencer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// multibyte_add_sequencer_if
// Request/response bundle for the sequencer.
//   Request : in_valid/in_ready handshake carrying op_a, op_b, op_sub, cin
//   Response: out_valid/out_ready handshake carrying result, cout, ovf
// Modports: master drives requests and consumes results; slave is the block.
// -----------------------------------------------------------------------------
interface multibyte_add_sequencer_if #(
    parameter int NBYTES = 4
);
    import multibyte_add_sequencer_pkg::*;

    localparam int W = BYTE_W * NBYTES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, ovf
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, result, cout, ovf
    );

endinterface

// File: rtl/multibyte_add_sequencer_ripple_carry_adder.sv
// -----------------------------------------------------------------------------
// ripple_carry_adder
// Combinational BYTE_W-bit adder built from a chain of full adders.
//   a, b - addends
//   ci   - carry in
//   sum  - BYTE_W-bit sum
//   co   - carry out of the most significant bit
// -----------------------------------------------------------------------------
module ripple_carry_adder
    import multibyte_add_sequencer_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              ci,
    output logic [BYTE_W-1:0] sum,
    output logic              co
);

    logic [BYTE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < BYTE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[BYTE_W];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// multibyte_add_sequencer
// Adds or subtracts two NBYTES-wide operands one byte per cycle through a
// single 8-bit ripple-carry adder, least significant byte first.
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - slave side of multibyte_add_sequencer_if (request/response)
// Timing: accept in IDLE, NBYTES cycles in RUN, result held in DONE until
// out_ready. Subtraction is A + ~B + 1, so cout=1 means "no borrow".
// -----------------------------------------------------------------------------
module multibyte_add_sequencer
    import multibyte_add_sequencer_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multibyte_add_sequencer_if.slave bus
);

    localparam int                 W        = BYTE_W * NBYTES;
    localparam int                 IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state;
    state_t            state_next;
    logic              in_ready_c;
    logic              out_valid_c;

    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;       // effective B (already inverted for subtract)
    logic              carry_q;
    logic [W-1:0]      result_q;
    logic              cout_q;
    logic              ovf_q;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] sum_byte;
    logic              carry_out;

    assign a_byte = a_q[idx * BYTE_W +: BYTE_W];
    assign b_byte = b_q[idx * BYTE_W +: BYTE_W];

    ripple_carry_adder u_adder (
        .a   (a_byte),
        .b   (b_byte),
        .ci  (carry_q),
        .sum (sum_byte),
        .co  (carry_out)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_next = RUN;
            end
            RUN: begin
                if (idx == LAST_IDX) state_next = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the operand registers are deliberately left out of reset; they are
    // always loaded on accept before anything reads them, so only the state
    // visible at the outputs (and the loop control) is cleared.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q <= bus.op_sub ? 1'b1 : bus.cin;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    result_q[idx * BYTE_W +: BYTE_W] <= sum_byte;
                    carry_q                         <= carry_out;
                    if (idx == LAST_IDX) begin
                        // Last byte: its sum MSB is the result sign bit.
                        idx    <= '0;
                        cout_q <= carry_out;
                        ovf_q  <= (a_q[W-1] == b_q[W-1]) &&
                                  (sum_byte[BYTE_W-1] != a_q[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_multibyte_add_sequencer
// Self-checking bench for multibyte_add_sequencer with NBYTES=4. A transaction
// level model predicts handshake timing and the arithmetic result; a compare
// process checks the DUT against it on every falling edge. Directed cases pin
// known answers, then randomized traffic (including resets) runs.
// -----------------------------------------------------------------------------
module tb_multibyte_add_sequencer;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multibyte_add_sequencer_if #(.NBYTES(NB)) bus ();

    multibyte_add_sequencer #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = waiting for a request, 1 = computing, 2 = result offered
    int           m_phase   = 0;
    int           m_cnt     = 0;
    logic         m_started = 1'b0;
    logic         m_known   = 1'b0;
    logic [W-1:0] m_res, p_res;
    logic         m_cout, m_ovf, p_cout, p_ovf;
    logic [W:0]   m_full;
    longint       m_s;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_started = 1'b1;
            m_phase   = 0;
            m_res     = '0;
            m_cout    = 1'b0;
            m_ovf     = 1'b0;
            m_known   = 1'b1;
        end else begin
            case (m_phase)
                0: if (bus.in_valid) begin
                    if (bus.op_sub) begin
                        p_res  = bus.op_a - bus.op_b;
                        p_cout = (bus.op_a >= bus.op_b);
                        m_s    = longint'($signed(bus.op_a)) - longint'($signed(bus.op_b));
                    end else begin
                        m_full = {1'b0, bus.op_a} + {1'b0, bus.op_b} + {{W{1'b0}}, bus.cin};
                        p_res  = m_full[W-1:0];
                        p_cout = m_full[W];
                        m_s    = longint'($signed(bus.op_a)) + longint'($signed(bus.op_b))
                               + longint'(bus.cin);
                    end
                    p_ovf   = (m_s > 64'sh7FFF_FFFF) || (m_s < -64'sh8000_0000);
                    m_cnt   = NB;
                    m_phase = 1;
                    m_known = 1'b0;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_res   = p_res;
                        m_cout  = p_cout;
                        m_ovf   = p_ovf;
                        m_known = 1'b1;
                    end
                end
                default: if (bus.out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", bus.in_ready, m_phase == 0);
            check("out_valid", bus.out_valid, m_phase == 2);
            if (m_known) begin
                check("result", bus.result, m_res);
                check("cout", bus.cout, m_cout);
                check("ovf", bus.ovf, m_ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Issues one request with the DUT idle, scrambles the inputs while it runs,
    // holds out_ready low for 'hold' cycles in DONE, then releases the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic c, input int hold,
                          output logic [W-1:0] r_first, output logic [W-1:0] r_last,
                          output logic co, output logic ov, output int lat);
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_sub    = sub;
        bus.cin       = c;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 64) begin
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            bus.op_sub   = 1'($urandom);
            bus.cin      = 1'($urandom);
            bus.in_valid = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        r_first = bus.result;
        co      = bus.cout;
        ov      = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            bus.op_a     = ~bus.op_a;
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
        end
        r_last        = bus.result;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("release_in_ready", bus.in_ready, 1);
        check("release_out_valid", bus.out_valid, 0);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] r0, r1;
        logic         co, ov;
        int           lat;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_sub    = 1'b0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);

        // 0x000000FF + 1: carry ripples into byte 1
        run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, r0, r1, co, ov, lat);
        check("add_ff_result", r0, 32'h0000_0100);
        check("add_ff_cout", co, 0);
        check("add_ff_ovf", ov, 0);
        check("add_ff_latency", lat, NB);

        // all-ones + 1 wraps to zero with carry out
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r0, r1, co, ov, lat);
        check("add_wrap_result", r0, 32'h0000_0000);
        check("add_wrap_cout", co, 1);
        check("add_wrap_ovf", ov, 0);

        // 5 - 7 borrows (cout=0); cin must be ignored for subtract
        run_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, r0, r1, co, ov, lat);
        check("sub_result", r0, 32'hFFFF_FFFE);
        check("sub_cout", co, 0);
        check("sub_ovf", ov, 0);

        // max positive + 1 overflows into the sign bit
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, r0, r1, co, ov, lat);
        check("ovf_result", r0, 32'h8000_0000);
        check("ovf_cout", co, 0);
        check("ovf_ovf", ov, 1);

        // result held for 3 stalled cycles while op_a toggles
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, 3, r0, r1, co, ov, lat);
        check("stall_first_result", r0, 32'h2345_678A);
        check("stall_last_result", r1, 32'h2345_678A);
        check("stall_latency", lat, NB);

        // reset during RUN at idx=2 aborts the operation
        bus.op_a     = 32'hDEAD_BEEF;
        bus.op_b     = 32'h0101_0101;
        bus.op_sub   = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_in_ready", bus.in_ready, 1);
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_result", bus.result, 0);

        // min negative - 1: signed overflow, no borrow
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1, r0, r1, co, ov, lat);
        check("post_rst_result", r0, 32'h7FFF_FFFF);
        check("post_rst_cout", co, 1);
        check("post_rst_ovf", ov, 1);
        check("post_rst_latency", lat, NB);

        // randomized traffic with random back-pressure and occasional resets
        for (int i = 0; i < 600; i++) begin
            rst_n         = ($urandom_range(0, 79) != 0);
            bus.in_valid  = 1'($urandom);
            bus.op_a      = pick_operand();
            bus.op_b      = pick_operand();
            bus.op_sub    = 1'($urandom);
            bus.cin       = 1'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (NB + 4) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
